// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle multiply/divide controller for the E stage.
// Owns the HI/LO registers, models MULT/DIV latency with a down-counter and
// raises busy/stall_req so the hazard unit can hold MD-class instructions in D.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      E-stage mult/multu/div/divu pulse
//   op         MD opcode (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//              5 mthi, 6 mtlo, 7 mfhi, 8 mflo)
//   rs_val     forwarded rs operand
//   rt_val     forwarded rt operand
//   d_md_use   D-stage instruction is MD-class
//   busy       computation in flight (registered)
//   stall_req  freeze request, combinational
//   hi, lo     architectural HI/LO (registered)
//   rdata      mfhi/mflo read data, combinational
module mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int unsigned MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        pend_hi;
  logic [31:0]        pend_lo;
  logic               pend_wr;

  logic [63:0] rs_sx, rt_sx, prod_s, prod_u;
  logic        sdiv, rs_neg, rt_neg, div_zero;
  logic [31:0] rs_mag, rt_mag, div_den, mag_q, mag_r, div_q, div_r;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;
  logic        is_calc, is_mult;

  // Result datapath: products and sign-magnitude division of the E operands.
  always_comb begin
    rs_sx  = {{32{rs_val[31]}}, rs_val};
    rt_sx  = {{32{rt_val[31]}}, rt_val};
    // Low 64 bits of the sign-extended product are the exact signed product.
    prod_s = rs_sx * rt_sx;
    prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    sdiv     = (op == OP_DIV);
    rs_neg   = sdiv & rs_val[31];
    rt_neg   = sdiv & rt_val[31];
    rs_mag   = rs_neg ? (~rs_val + 32'd1) : rs_val;
    rt_mag   = rt_neg ? (~rt_val + 32'd1) : rt_val;
    div_zero = (rt_val == 32'd0);
    // Dummy divisor keeps the divider defined; the result is discarded anyway.
    div_den  = div_zero ? 32'd1 : rt_mag;
    mag_q    = rs_mag / div_den;
    mag_r    = rs_mag % div_den;
    // -2^31 / -1 falls out naturally: magnitude 0x80000000, sign positive.
    div_q    = (rs_neg ^ rt_neg) ? (~mag_q + 32'd1) : mag_q;
    div_r    = rs_neg ? (~mag_r + 32'd1) : mag_r;

    res_hi = prod_s[63:32];
    res_lo = prod_s[31:0];
    res_wr = 1'b1;
    case (op)
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV, OP_DIVU: begin
        res_hi = div_r;
        res_lo = div_q;
        res_wr = ~div_zero;
      end
      default: ;
    endcase

    is_calc = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    is_mult = (op == OP_MULT) || (op == OP_MULTU);
  end

  // Sequencer: latch the result at start, hold busy for N cycles, then commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && is_calc) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
            cnt     <= is_mult ? MULT_LOAD : DIV_LOAD;
            busy    <= 1'b1;
            state   <= S_RUN;
          end else if (op == OP_MTHI) begin
            hi <= rs_val;
          end else if (op == OP_MTLO) begin
            lo <= rs_val;
          end
        end
        S_RUN: begin
          if (cnt == '0) begin
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stall also covers the start cycle so a second MD op never pairs with it.
  always_comb begin
    stall_req = d_md_use & (busy | start);
    case (op)
      OP_MFHI: rdata = hi;
      OP_MFLO: rdata = lo;
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed plus randomized check of mdu_sequencer against a
// behavioural HI/LO model that tracks the remaining busy time as a plain count.
module tb_mdu_sequencer;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_md_use;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  mdu_sequencer #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .d_md_use (d_md_use),
    .busy     (busy),
    .stall_req(stall_req),
    .hi       (hi),
    .lo       (lo),
    .rdata    (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_wr;
  int          m_left;

  // The hazard unit must never let a start reach E during a computation.
  always @(negedge clk) begin
    if (reset) begin
      assert (!(start && busy)) else $error("FAIL start_while_busy");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural effect of one clock edge with the given inputs.
  task automatic model_edge(input logic st, input logic [3:0] o,
                            input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_wr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (st && o >= 4'd1 && o <= 4'd4) begin
      m_wr = 1'b1;
      case (o)
        4'd1: begin p = sa * sb; m_phi = p[63:32]; m_plo = p[31:0]; end
        4'd2: begin up = ua * ub; m_phi = up[63:32]; m_plo = up[31:0]; end
        4'd3: begin
          if (b == 32'd0) m_wr = 1'b0;
          else begin q = sa / sb; r = sa % sb; m_plo = q[31:0]; m_phi = r[31:0]; end
        end
        default: begin
          if (b == 32'd0) m_wr = 1'b0;
          else begin up = ua / ub; m_plo = up[31:0]; up = ua % ub; m_phi = up[31:0]; end
        end
      endcase
      m_left = (o <= 4'd2) ? int'(MULT_N) : int'(DIV_N);
    end else if (o == 4'd5) begin
      m_hi = a;
    end else if (o == 4'd6) begin
      m_lo = a;
    end
  endtask

  // One cycle: drive at posedge+1, check combinational outputs, step edge, check state.
  task automatic drive_cycle(input logic st, input logic [3:0] o,
                             input logic [31:0] a, input logic [31:0] b, input logic dmd);
    logic [31:0] exp_rd;
    start = st; op = o; rs_val = a; rt_val = b; d_md_use = dmd;
    #1;
    exp_rd = (o == 4'd7) ? m_hi : (o == 4'd8) ? m_lo : 32'd0;
    check("stall_req", 32'(stall_req), 32'(dmd & ((m_left > 0) | st)));
    check("rdata", rdata, exp_rd);
    @(posedge clk);
    model_edge(st, o, a, b);
    #1;
    check("busy", 32'(busy), 32'(m_left > 0));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  endtask

  // Idle E stage until busy falls (bounded); n = cycles busy stayed high.
  task automatic run_busy(input logic dmd, input logic [3:0] o, input logic [31:0] a, output int n);
    n = 0;
    while (busy && n < 100) begin
      drive_cycle(1'b0, o, a, 32'd0, dmd);
      n++;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          n;
    logic        st, dmd;
    logic [3:0]  o;
    logic [31:0] a, b;

    reset = 1'b0; start = 1'b0; op = 4'd0; rs_val = 32'd0; rt_val = 32'd0; d_md_use = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0; m_wr = 1'b0; m_left = 0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive_cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

    // mult -2 * 3
    drive_cycle(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
    check("mult_busy_start", 32'(busy), 32'd1);
    run_busy(1'b1, 4'd0, 32'd0, n);
    check("mult_cycles", 32'(n), 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // multu accepted in the first idle cycle
    drive_cycle(1'b1, 4'd2, 32'hFFFF_FFFE, 32'd3, 1'b1);
    check("b2b_accept", 32'(busy), 32'd1);
    run_busy(1'b1, 4'd0, 32'd0, n);
    check("multu_cycles", 32'(n), 32'd5);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);
    drive_cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    check("stall_after_busy", 32'(stall_req), 32'd0);

    // div -7 / 2 with no MD op in D
    drive_cycle(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("stall_no_dmd", 32'(stall_req), 32'd0);
    run_busy(1'b0, 4'd0, 32'd0, n);
    check("div_cycles", 32'(n), 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // divu by zero leaves preloaded HI/LO
    drive_cycle(1'b0, 4'd5, 32'h11, 32'd0, 1'b0);
    drive_cycle(1'b0, 4'd6, 32'h22, 32'd0, 1'b0);
    drive_cycle(1'b1, 4'd4, 32'd7, 32'd0, 1'b1);
    run_busy(1'b1, 4'd0, 32'd0, n);
    check("div0_cycles", 32'(n), 32'd10);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    // -2^31 / -1
    drive_cycle(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_busy(1'b0, 4'd0, 32'd0, n);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);

    // mthi in idle, mfhi next cycle
    drive_cycle(1'b0, 4'd5, 32'hABCD_0123, 32'd0, 1'b0);
    check("mthi_busy", 32'(busy), 32'd0);
    check("mthi_hi", hi, 32'hABCD_0123);
    drive_cycle(1'b0, 4'd7, 32'd0, 32'd0, 1'b0);
    check("mfhi_rdata", rdata, 32'hABCD_0123);

    // mthi during RUN is ignored
    drive_cycle(1'b1, 4'd1, 32'd3, 32'd4, 1'b1);
    run_busy(1'b1, 4'd5, 32'hDEAD_BEEF, n);
    check("run_mthi_hi", hi, 32'd0);
    check("run_mthi_lo", lo, 32'd12);

    // asynchronous reset mid-run aborts the write
    drive_cycle(1'b1, 4'd2, 32'd7, 32'd9, 1'b0);
    drive_cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    drive_cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_hi", hi, 32'd0);
    check("async_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_wr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 12; i++) drive_cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    check("abort_lo", lo, 32'd0);

    // randomized traffic; start only offered while the model is idle
    for (int i = 0; i < 600; i++) begin
      o   = 4'($urandom_range(0, 15));
      a   = pick();
      b   = pick();
      st  = (m_left == 0) && ($urandom_range(0, 2) != 0);
      dmd = 1'($urandom_range(0, 1));
      drive_cycle(st, o, a, b, dmd);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
